// File: rtl/ptw_ml.sv
// Multi-level radix page table walker: walks up to LEVELS PTE reads from a
// runtime root PPN, supports superpage leaves and reports the ending level.
module ptw_ml #(
  parameter int LEVELS = 2,
  parameter int VPN_W  = 10,
  parameter int OFF_W  = 12,
  parameter int ADDR_W = 32,
  localparam int VA_W  = LEVELS*VPN_W + OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [21:0]       satp_ppn_i,
  input  logic              ptw_req_valid_i,
  output logic              ptw_req_ready_o,
  input  logic [VA_W-1:0]   ptw_vaddr_i,
  output logic              ptw_resp_valid_o,
  input  logic              ptw_resp_ready_i,
  output logic [31:0]       ptw_pte_o,
  output logic [1:0]        ptw_level_o,
  output logic              ptw_fault_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_resp_valid_i,
  output logic              mem_resp_ready_o,
  input  logic [31:0]       mem_data_i
);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  localparam logic [1:0] TOP_LVL = 2'(LEVELS-1);

  state_t          state;
  logic [VA_W-1:0] vaddr_q;
  logic [1:0]      lvl;

  logic        pte_v, pte_r, pte_w, pte_x;
  logic [21:0] sp_mask;
  logic        misaligned;
  logic        walk_end;
  logic        walk_fault;

  // Byte address of the PTE indexed by vpn[l] inside the table at ppn.
  function automatic logic [ADDR_W-1:0] pte_addr(input logic [21:0]     ppn,
                                                 input logic [VA_W-1:0] va,
                                                 input logic [1:0]      l);
    logic [VPN_W-1:0] vpn;
    vpn = VPN_W'(va >> (OFF_W + int'(l)*VPN_W));
    return (ADDR_W'(ppn) << OFF_W) + (ADDR_W'(vpn) << 2);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pte_v      = mem_data_i[0];
    pte_r      = mem_data_i[1];
    pte_w      = mem_data_i[2];
    pte_x      = mem_data_i[3];
    sp_mask    = 22'((64'd1 << (int'(lvl)*VPN_W)) - 64'd1);
    misaligned = |(mem_data_i[31:10] & sp_mask);
    walk_end   = 1'b1;
    walk_fault = 1'b1;
    if (!pte_v || (!pte_r && pte_w)) begin
      walk_end   = 1'b1;
      walk_fault = 1'b1;
    end else if (pte_r || pte_x) begin
      walk_end   = 1'b1;
      walk_fault = misaligned;
    end else begin
      // Pointer: only legal above the last level.
      walk_end   = (lvl == 2'd0);
      walk_fault = (lvl == 2'd0);
    end
  end

  // All outputs are flops updated alongside the state, so none decode state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, avoiding
    // read-before-write races between clocked blocks.
    if (rst) begin
      state            <= IDLE;
      vaddr_q          <= '0;
      lvl              <= '0;
      ptw_req_ready_o  <= 1'b1;
      ptw_resp_valid_o <= 1'b0;
      ptw_pte_o        <= '0;
      ptw_level_o      <= '0;
      ptw_fault_o      <= 1'b0;
      mem_req_valid_o  <= 1'b0;
      mem_addr_o       <= '0;
      mem_resp_ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ptw_req_valid_i) begin
            vaddr_q         <= ptw_vaddr_i;
            lvl             <= TOP_LVL;
            mem_addr_o      <= pte_addr(satp_ppn_i, ptw_vaddr_i, TOP_LVL);
            mem_req_valid_o <= 1'b1;
            ptw_req_ready_o <= 1'b0;
            state           <= MREQ;
          end
        end
        MREQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o  <= 1'b0;
            mem_resp_ready_o <= 1'b1;
            state            <= MWAIT;
          end
        end
        MWAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_o <= 1'b0;
            if (walk_end) begin
              ptw_pte_o        <= mem_data_i;
              ptw_level_o      <= lvl;
              ptw_fault_o      <= walk_fault;
              ptw_resp_valid_o <= 1'b1;
              state            <= RESP;
            end else begin
              lvl             <= lvl - 2'd1;
              mem_addr_o      <= pte_addr(mem_data_i[31:10], vaddr_q, lvl - 2'd1);
              mem_req_valid_o <= 1'b1;
              state           <= MREQ;
            end
          end
        end
        RESP: begin
          if (ptw_resp_ready_i) begin
            ptw_resp_valid_o <= 1'b0;
            ptw_req_ready_o  <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ptw_ml.md
# ptw_ml

Parametrised multi-level page table walker; next generation of the TLB-side two-level walker. Translates a virtual address by walking up to LEVELS radix page-table levels in memory, starting from a runtime root PPN. It recognises leaf PTEs at any level (superpages) and reports page faults with the terminating level. It sits between the TLB miss path and the memory port, using valid/ready handshakes on both sides.

## Interface
- LEVELS, 2, page-table levels, 1..4; level LEVELS-1 is root, level 0 is last.
- VPN_W, 10, VPN bits per level.
- OFF_W, 12, page-offset bits; virtual address width VA_W = LEVELS*VPN_W + OFF_W.
- ADDR_W, 32, physical/memory address width.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- satp_ppn_i  in  22  root table PPN, sampled at request accept
- ptw_req_valid_i  in  1  walk request valid
- ptw_req_ready_o  out  1  walker idle and accepting
- ptw_vaddr_i  in  VA_W  virtual address
- ptw_resp_valid_o  out  1  result valid
- ptw_resp_ready_i  in  1  result consumed
- ptw_pte_o  out  32  final PTE read (leaf or faulting entry)
- ptw_level_o  out  2  level at which walk ended
- ptw_fault_o  out  1  page fault
- mem_req_valid_o  out  1  memory read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  ADDR_W  PTE byte address
- mem_resp_valid_i  in  1  read data valid
- mem_resp_ready_o  out  1  walker accepts read data
- mem_data_i  in  32  PTE read data

## Operation
- PTE format: V=bit0, R=bit1, W=bit2, X=bit3, PPN=bits[31:10].
- States: IDLE, MREQ, MWAIT, RESP. Level counter lvl and registered vaddr, base PPN.
- IDLE: ptw_req_ready_o=1. On valid&ready: latch vaddr and satp_ppn_i, lvl<=LEVELS-1, go MREQ.
- MREQ: mem_req_valid_o=1, mem_addr_o = (base<<OFF_W) + (vpn[lvl]<<2), truncated to ADDR_W. vpn[i] = vaddr[OFF_W+i*VPN_W +: VPN_W]. Address and valid are held stable until mem_req_ready_i; then go MWAIT.
- MWAIT: mem_resp_ready_o=1. On response handshake, classify the PTE:
  - Fault if V=0, or R=0 with W=1.
  - Leaf if R|X=1. The walk ends with fault=0 unless lvl>0 and PTE[10 +: lvl*VPN_W]!=0 (misaligned superpage), which faults.
  - Pointer if R=W=X=0 and V=1. If lvl==0 it faults. Otherwise base<=PPN, lvl<=lvl-1, go MREQ.
  - On any end: ptw_pte_o<=raw PTE, ptw_level_o<=lvl, ptw_fault_o per rules above, go RESP.
- RESP: ptw_resp_valid_o=1, outputs held stable until ptw_resp_ready_i. On handshake go IDLE.
- One walk outstanding at a time. Never more than one memory request in flight.
- Inputs ptw_vaddr_i and satp_ppn_i are ignored outside the accept cycle.

## Timing
- All outputs are registered.
- Reset values: ptw_req_ready_o=1, all other valids/readies 0, ptw_pte_o=0, ptw_level_o=0, ptw_fault_o=0, mem_addr_o=0. State is IDLE.
- Accept at cycle t, then mem_req_valid_o=1 at t+1.
- Request handshake at cycle c, then mem_resp_ready_o=1 from c+1 until the response handshake, deasserted the next cycle.
- With memory always ready and responding the cycle after acceptance, ptw_resp_valid_o rises at t+2N+1, where N = PTE reads (N=2 gives t+5; N=1 leaf at root gives t+3).
- ptw_req_ready_o is 0 from t+1 until the cycle after the response handshake.
- Back-to-back: the next request can be accepted the cycle after the response handshake.
- mem_req_valid_o never drops before ready (no request withdrawal). mem_resp_valid_i outside MWAIT is ignored.
- rst mid-walk: next cycle is IDLE with reset outputs. A pending memory response arrives with mem_resp_ready_o=0 and is not consumed by the walker; the memory side must drop it on the same reset.

## Test plan
- LEVELS=2, satp_ppn=0x1, vaddr=0x00403abc. Root PTE at 0x1004 =0x00000801 (pointer to PPN 0x2); L0 PTE at 0x200C =0x0000340F. Expect pte=0x0000340F, level=0, fault=0; memory addresses 0x1004 then 0x200C; resp_valid at t+5.
- Superpage: root PTE =0x00400007 (PPN 0x1000, low 10 bits zero). Expect level=1, fault=0, one memory read. Root PTE =0x00400407 instead gives fault=1, level=1.
- Invalid root PTE 0x00000000: expect fault=1, level=1, pte=0, no second read. L0 PTE =0x00000001 (pointer at last level): expect fault=1, level=0.
- Backpressure: hold mem_req_ready_i=0 for 3 cycles and ptw_resp_ready_i=0 for 4 cycles. Expect mem_addr_o and the response outputs stable throughout, and ptw_req_ready_o low until release.
- Reset asserted during MWAIT of level 0: expect all outputs at reset values next cycle. A following walk completes correctly.
- LEVELS=3, VPN_W=9, OFF_W=12 (VA_W=39): three-level walk ending in a 4 KiB leaf. Expect three reads, level=0, resp_valid at t+7.
